// File: rtl/cipher_uart_loader_if.sv
// Bundle of signals between the UART loader and its environment.
// The loader (slave) receives rx/en/clear and drives the byte/strobe side.
`timescale 1ns/1ps

interface cipher_uart_loader_if;
    logic       rx;
    logic       en;
    logic       clear;
    logic [7:0] byte_out;
    logic       inc;
    logic       encrypt;
    logic [3:0] byte_count;
    logic       overflow;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx, en, clear,
        output byte_out, inc, encrypt, byte_count, overflow, frame_err, busy
    );

    modport master (
        output rx, en, clear,
        input  byte_out, inc, encrypt, byte_count, overflow, frame_err, busy
    );
endinterface

// File: rtl/cipher_uart_loader.sv
// 8N1 UART receiver that presents each good byte to the cipher store with
// a registered, glitch-free inc strobe framed by a setup cycle and a hold
// cycle. Counts forwarded bytes, saturating at the store depth.
`timescale 1ns/1ps

module cipher_uart_loader #(
    parameter int CLK_DIV   = 16,
    parameter int INC_WIDTH = 2,
    parameter int MAX_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cipher_uart_loader_if.slave   bus
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [TW-1:0] TMR_MID   = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TMR_END   = TW'(CLK_DIV - 1);
    localparam logic [3:0]    STRB_LAST = 4'(INC_WIDTH - 1);
    localparam logic [3:0]    CNT_MAX   = 4'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4,
        S_SETUP  = 3'd5,
        S_STROBE = 3'd6,
        S_HOLD   = 3'd7
    } state_t;

    logic          r_rx_meta;
    logic          r_rxs;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [3:0]    r_strb_cnt;
    logic [7:0]    r_byte_out;
    logic          r_inc;
    logic          r_encrypt;
    logic [3:0]    r_byte_count;
    logic          r_overflow;
    logic          r_frame_err;
    logic          r_busy;

    state_t        w_next_state;
    logic          w_timer_mid;
    logic          w_timer_end;
    logic          w_accept;
    logic          w_frame_err_next;
    logic          w_strobe_entry;
    logic          w_inc_next;
    logic          w_busy_next;

    assign w_timer_mid = (r_timer == TMR_MID);
    assign w_timer_end = (r_timer == TMR_END);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) w_next_state = S_START;
                else        w_next_state = S_IDLE;
            end
            S_START: begin
                if (w_timer_mid) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!r_rxs) w_next_state = S_DATA;
                    else        w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (w_timer_end && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
                else                                    w_next_state = S_DATA;
            end
            S_STOP: begin
                if (w_timer_end) begin
                    if (!r_rxs)      w_next_state = S_BREAK;
                    else if (bus.en) w_next_state = S_SETUP;
                    else             w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_STOP;
                end
            end
            S_BREAK: begin
                // Stay here until the line returns high so a held-low line
                // reports only one framing error.
                if (r_rxs) w_next_state = S_IDLE;
                else       w_next_state = S_BREAK;
            end
            S_SETUP:  w_next_state = S_STROBE;
            S_STROBE: begin
                if (r_strb_cnt == STRB_LAST) w_next_state = S_HOLD;
                else                         w_next_state = S_STROBE;
            end
            S_HOLD:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode; every value here is registered before leaving the block.
    always_comb begin
        w_accept         = 1'b0;
        w_frame_err_next = 1'b0;
        w_strobe_entry   = 1'b0;
        w_inc_next       = (w_next_state == S_STROBE);
        w_busy_next      = (w_next_state != S_IDLE);
        if ((r_state == S_STOP) && w_timer_end) begin
            w_accept         = r_rxs & bus.en;
            w_frame_err_next = ~r_rxs;
        end else begin
            w_accept         = 1'b0;
            w_frame_err_next = 1'b0;
        end
        if ((r_state == S_SETUP) && (w_next_state == S_STROBE)) begin
            w_strobe_entry = 1'b1;
        end else begin
            w_strobe_entry = 1'b0;
        end
    end

    // Bit timer, bit index, LSB-first shift register and strobe-width counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= TMR_ZERO;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_strb_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_START: begin
                    r_timer   <= w_timer_mid ? TMR_ZERO : (r_timer + TMR_ONE);
                    r_bit_idx <= 3'd0;
                end
                S_DATA: begin
                    r_timer <= w_timer_end ? TMR_ZERO : (r_timer + TMR_ONE);
                    if (w_timer_end) begin
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    r_timer <= w_timer_end ? TMR_ZERO : (r_timer + TMR_ONE);
                end
                default: begin
                    r_timer   <= TMR_ZERO;
                    r_bit_idx <= 3'd0;
                end
            endcase
            if (r_state == S_STROBE) r_strb_cnt <= r_strb_cnt + 4'd1;
            else                     r_strb_cnt <= 4'd0;
        end
    end

    // Registered outputs toward the cipher store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_out  <= 8'h00;
            r_inc       <= 1'b0;
            r_encrypt   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) r_byte_out <= r_shift;
            r_inc       <= w_inc_next;
            r_encrypt   <= bus.en;
            r_frame_err <= w_frame_err_next;
            r_busy      <= w_busy_next;
        end
    end

    // Saturating byte counter with sticky overflow; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= 4'd0;
            r_overflow   <= 1'b0;
        end else if (bus.clear) begin
            r_byte_count <= 4'd0;
            r_overflow   <= 1'b0;
        end else if (w_strobe_entry) begin
            if (r_byte_count == CNT_MAX) r_overflow   <= 1'b1;
            else                         r_byte_count <= r_byte_count + 4'd1;
        end
    end

    assign bus.byte_out   = r_byte_out;
    assign bus.inc        = r_inc;
    assign bus.encrypt    = r_encrypt;
    assign bus.byte_count = r_byte_count;
    assign bus.overflow   = r_overflow;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = r_busy;

endmodule
